// File: rtl/shared_resource_arbiter.sv
// shared_resource_arbiter
// Round-robin front end for one fixed-latency compute resource shared by
// NUM_REQ pipeline instances. One operation is accepted per cycle; its
// requester tag travels with it down a LATENCY-stage pipeline so that the
// result can be steered back to the owner as a one-hot valid.
module shared_resource_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2,
  parameter int OP_INC  = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*DATA_W-1:0]         req_data,
  input  logic                              flush,
  input  logic                              res_stall,
  output logic [NUM_REQ-1:0]                grant,
  output logic [DATA_W-1:0]                 res_data,
  output logic [NUM_REQ-1:0]                res_valid,
  output logic [$clog2(LATENCY+1)-1:0]      inflight
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LATENCY+1);

  // Round-robin pointer: the requester searched first in the next cycle.
  logic [PTR_W-1:0]  r_ptr;

  // Resource pipeline stages; index LATENCY-1 is the result stage.
  logic              r_valid [LATENCY];
  logic [PTR_W-1:0]  r_tag   [LATENCY];
  logic [DATA_W-1:0] r_data  [LATENCY];

  logic [DATA_W-1:0] w_operand [NUM_REQ];
  logic [PTR_W-1:0]  w_cand;
  logic [PTR_W-1:0]  w_grant_idx;
  logic              w_grant_any;
  logic [PTR_W-1:0]  w_next_ptr;
  logic              w_out_valid;
  logic [CNT_W-1:0]  w_count;

  // Unpack the flat operand bus so the winner can be selected by index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_operand
    assign w_operand[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Find the first requester at or after r_ptr (wrapping); suppressed while
  // the resource is frozen, flushed or held in reset.
  always_comb begin
    w_cand      = '0;
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    if (!reset && !flush && !res_stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_cand = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
        if (!w_grant_any && req[w_cand]) begin
          w_grant_any = 1'b1;
          w_grant_idx = w_cand;
        end
      end
    end
  end

  // One-hot grant decode of the winning index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant[gi] = w_grant_any && (w_grant_idx == PTR_W'(gi));
  end

  assign w_next_ptr = PTR_W'((int'(w_grant_idx) + 1) % NUM_REQ);

  // Pointer advances past the winner only on an actual accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_grant_any) begin
      r_ptr <= w_next_ptr;
    end
  end

  // Stage pipeline: flush wins over stall; stall freezes every stage so a
  // held result is presented again once the stall lifts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) begin
        r_valid[k] <= 1'b0;
        r_tag[k]   <= '0;
        r_data[k]  <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < LATENCY; k++) begin
        r_valid[k] <= 1'b0;
      end
    end else if (!res_stall) begin
      r_valid[0] <= w_grant_any;
      if (w_grant_any) begin
        r_tag[0]  <= w_grant_idx;
        r_data[0] <= w_operand[w_grant_idx] + DATA_W'(OP_INC);
      end
      for (int k = 1; k < LATENCY; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_tag[k]   <= r_tag[k-1];
        r_data[k]  <= r_data[k-1];
      end
    end
  end

  // The result stage is only shown when the resource is not frozen.
  assign w_out_valid = !reset && r_valid[LATENCY-1] && !res_stall;
  assign res_data    = w_out_valid ? r_data[LATENCY-1] : '0;

  // Steer the result valid to the requester named by the stage tag.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_res_valid
    assign res_valid[gi] = w_out_valid && (r_tag[LATENCY-1] == PTR_W'(gi));
  end

  // Count of occupied stages, straight from the stage registers.
  always_comb begin
    w_count = '0;
    for (int k = 0; k < LATENCY; k++) begin
      w_count = w_count + CNT_W'(r_valid[k]);
    end
  end

  assign inflight = w_count;

endmodule
